// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit pair per clock, LSB first, WIDTH+1 cycles per sum.
// Full-adder cell is built from two half adders and an OR of their carries.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s0, w_c0, w_c1;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
  half_adder u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s),  .o_c(w_c1));

  assign o_c = w_c0 | w_c1;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_psum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_last = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_ADD;
        end
      end
      S_ADD: begin
        busy = 1'b1;
        if (r_cnt == LAST) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // A start here reloads immediately, so back-to-back sums cost WIDTH+1 cycles each.
        if (start) begin
          w_load = 1'b1;
          w_next = S_ADD;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  full_adder u_fa (
    .i_a(r_a[0]),
    .i_b(r_b[0]),
    .i_c(r_carry),
    .o_s(w_s),
    .o_c(w_c)
  );

  // The partial sum holds WIDTH-1 bits; the final bit joins it on the completion edge.
  assign w_sum_next = {w_s, r_psum};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a     <= A;
      r_b     <= B;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (busy) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_psum  <= w_sum_next[WIDTH-1:1];
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_c;
      end
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected {Cout,Sum} queued at start, compared at done.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_res;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .Sum(Sum), .Cout(Cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    #1;
    start = 1'b0;
    A = WIDTH'($urandom);
    B = WIDTH'($urandom);
  endtask

  // Waits for done (bounded); reports busy cycles seen and whether outputs held hold_res.
  task automatic wait_done(input logic [WIDTH:0] hold_res, output int nbusy,
                           output bit got, output bit held);
    nbusy = 0; got = 1'b0; held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (busy) nbusy++;
      if ({Cout, Sum} !== hold_res) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    checks++; if (Sum !== '0)   begin errors++; $display("FAIL reset_sum: got %h want 00", Sum); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", Cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
    last_res = '0;
  endtask

  task automatic test_basic();
    int nb; bit got, held; logic [WIDTH:0] e;
    do_start(8'h35, 8'h4A);
    wait_done(last_res, nb, got, held);
    checks++; if (!got) begin errors++; $display("FAIL basic_done: no done pulse within bound"); end
    checks++; if (nb != WIDTH) begin errors++; $display("FAIL basic_busy_len: got %0d want %0d", nb, WIDTH); end
    checks++; if (!held) begin errors++; $display("FAIL basic_hold: Sum/Cout changed during ADD"); end
    e = exp_q.pop_front();
    checks++; if ({Cout, Sum} !== e) begin errors++; $display("FAIL basic_result: got %h want %h", {Cout, Sum}, e); end
    last_res = e;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: done still %b", done); end
  endtask

  task automatic test_carry_ripple();
    int nb; bit got, held; logic [WIDTH:0] e;
    logic [WIDTH-1:0] pa[2] = '{8'hFF, 8'hFF};
    logic [WIDTH-1:0] pb[2] = '{8'h01, 8'hFF};
    logic [WIDTH:0]   want[2] = '{9'h100, 9'h1FE};
    for (int k = 0; k < 2; k++) begin
      do_start(pa[k], pb[k]);
      wait_done(last_res, nb, got, held);
      checks++; if (!got) begin errors++; $display("FAIL ripple_done[%0d]: no done pulse", k); end
      e = exp_q.pop_front();
      checks++; if (e !== want[k]) begin errors++; $display("FAIL ripple_model[%0d]: got %h want %h", k, e, want[k]); end
      checks++; if ({Cout, Sum} !== e) begin errors++; $display("FAIL ripple_result[%0d]: got %h want %h", k, {Cout, Sum}, e); end
      last_res = e;
    end
  endtask

  task automatic test_start_ignored();
    int nd; bit held; logic [WIDTH:0] e, r;
    do_start(8'h10, 8'h20);
    nd = 0; held = 1'b1; r = 'x;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) begin nd++; r = {Cout, Sum}; end
      else if (busy && ({Cout, Sum} !== last_res)) held = 1'b0;
      if (i == 2) begin start = 1'b1; A = 8'hAA; B = 8'h55; end
      else start = 1'b0;
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    checks++; if (!held) begin errors++; $display("FAIL ignore_hold: Sum/Cout changed during ADD"); end
    e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL ignore_result: got %h want %h", r, e); end
    last_res = e;
  endtask

  task automatic test_back_to_back();
    int nd, first_i; logic [WIDTH:0] e;
    @(negedge clk);
    A = 8'h01; B = 8'h02; start = 1'b1;
    exp_q.push_back(9'h003);
    nd = 0; first_i = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        e = exp_q.pop_front();
        nd++;
        checks++; if ({Cout, Sum} !== e) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", nd, {Cout, Sum}, e); end
        if (nd == 1) begin
          first_i = i;
          A = 8'h80; B = 8'h80;
          exp_q.push_back(9'h100);
        end else begin
          checks++; if (i - first_i != WIDTH + 1) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", i - first_i, WIDTH + 1); end
          last_res = e;
          break;
        end
      end
    end
    start = 1'b0;
    checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    int nb, nd; bit got, held; logic [WIDTH:0] e;
    do_start(8'h0F, 8'h01);
    wait_done(last_res, nb, got, held);
    e = exp_q.pop_front();
    checks++; if ({Cout, Sum} !== e) begin errors++; $display("FAIL abort_pre_result: got %h want %h", {Cout, Sum}, e); end
    do_start(8'h33, 8'h44);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if ({Cout, Sum} !== '0) begin errors++; $display("FAIL abort_result: got %h want 000", {Cout, Sum}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    nd = 0;
    repeat (12) begin @(negedge clk); if (done) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_stray_done: got %0d want 0", nd); end
    do_start(8'h02, 8'h03);
    wait_done(last_res, nb, got, held);
    checks++; if (!got || nb != WIDTH) begin errors++; $display("FAIL abort_post_timing: done %b busy %0d want 1 %0d", got, nb, WIDTH); end
    e = exp_q.pop_front();
    checks++; if ({Cout, Sum} !== e) begin errors++; $display("FAIL abort_post_result: got %h want %h", {Cout, Sum}, e); end
    last_res = e;
  endtask

  task automatic test_random();
    int nb; bit got, held; logic [WIDTH:0] e;
    logic [WIDTH-1:0] a, b;
    for (int n = 0; n < 202; n++) begin
      if (n == 0)      begin a = 8'h00; b = 8'h00; end
      else if (n == 1) begin a = 8'h80; b = 8'h7F; end
      else begin a = WIDTH'($urandom); b = WIDTH'($urandom); end
      do_start(a, b);
      wait_done(last_res, nb, got, held);
      e = exp_q.pop_front();
      checks++; if (!got) begin errors++; $display("FAIL rand_done[%0d]: no done pulse", n); end
      checks++; if (!held) begin errors++; $display("FAIL rand_hold[%0d]: outputs moved during ADD, want %h", n, last_res); end
      checks++; if ({Cout, Sum} !== e) begin errors++; $display("FAIL rand_result[%0d]: %h+%h got %h want %h", n, a, b, {Cout, Sum}, e); end
      last_res = e;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
